// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - lib_cpu package: OPECODE enum and opcode decoder
package lib_cpu;

  typedef enum logic [3:0] {
    MOV_A_B,
    MOV_B_A,
    MOV_A_IMM,
    MOV_B_IMM,
    IN_A,
    IN_B,
    OUT_B,
    OUT_IMM,
    ADD_A_IMM,
    ADD_B_IMM,
    JMP_IMM,
    JNC_IMM,
    INVALID = 4'hF
  } opecode_e;

  function automatic opecode_e decode_op(input logic [3:0] opcode);
    opecode_e op;
    case (opcode)
      4'b0001: op = MOV_A_B;
      4'b0100: op = MOV_B_A;
      4'b0011: op = MOV_A_IMM;
      4'b0111: op = MOV_B_IMM;
      4'b0010: op = IN_A;
      4'b0110: op = IN_B;
      4'b1001: op = OUT_B;
      4'b1011: op = OUT_IMM;
      4'b0000: op = ADD_A_IMM;
      4'b0101: op = ADD_B_IMM;
      4'b1111: op = JMP_IMM;
      4'b1110: op = JNC_IMM;
      default: op = INVALID;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_queue_fifo.sv
// rtl/decode_queue_fifo.sv - decode_fifo: DEPTH-entry storage with pointers, level and flush
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when the head is leaving in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload is never observed while empty, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode stage queue; DECODE_QUEUE_TRAP_EN adds the illegal-opcode trap
module decode_queue
  import lib_cpu::*;
#(
  parameter int IMM_W = 4,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  localparam int INSTR_W = 4 + IMM_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INSTR_W-1:0]         in_instr_i,
  input  logic [PC_W-1:0]            in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output opecode_e                   out_opecode_o,
  output logic [IMM_W-1:0]           out_imm_o,
  output logic [PC_W-1:0]            out_pc_o,
  input  logic                       flush_i,
`ifdef DECODE_QUEUE_TRAP_EN
  output logic                       trap_o,
  input  logic                       trap_clr_i,
  output logic [PC_W-1:0]            trap_pc_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  typedef struct packed {
    opecode_e               op;
    logic [IMM_W-1:0]       imm;
    logic [PC_W-1:0]        pc;
  } dec_entry_t;

  dec_entry_t wr_entry, head;
  logic       fifo_full, fifo_empty;
  logic       accept, push;

  assign wr_entry.op  = decode_op(in_instr_i[INSTR_W-1 -: 4]);
  assign wr_entry.imm = in_instr_i[IMM_W-1:0];
  assign wr_entry.pc  = in_pc_i;

  assign accept = in_valid_i && in_ready_o;

`ifdef DECODE_QUEUE_TRAP_EN
  typedef enum logic {RUN, TRAP} trap_state_e;

  trap_state_e      state_q, state_d;
  logic [PC_W-1:0]  trap_pc_q, trap_pc_d;

  // A faulting word is swallowed here rather than queued; a flush cancels the push.
  always_comb begin
    state_d   = state_q;
    trap_pc_d = trap_pc_q;
    push      = accept;
    case (state_q)
      RUN: begin
        if (accept && !flush_i && wr_entry.op == INVALID) begin
          state_d   = TRAP;
          trap_pc_d = in_pc_i;
          push      = 1'b0;
        end
      end
      TRAP: begin
        if (trap_clr_i || flush_i) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign in_ready_o = !fifo_full && (state_q == RUN);
  assign trap_o     = (state_q == TRAP);
  assign trap_pc_o  = trap_pc_q;
`else
  assign in_ready_o = !fifo_full;
  assign push       = accept;
`endif

  decode_fifo #(
    .WIDTH ($bits(dec_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (out_ready_i),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign out_valid_o   = !fifo_empty;
  assign out_opecode_o = fifo_empty ? INVALID : head.op;
  assign out_imm_o     = fifo_empty ? '0 : head.imm;
  assign out_pc_o      = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized self-checking bench for decode_queue (DEPTH 2 and 4)
module tb_decode_queue;
  import lib_cpu::*;

  typedef struct {
    opecode_e    op;
    logic [3:0]  imm;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush, trap_clr;
  logic [7:0]  in_instr;
  logic [31:0] in_pc;

  logic        ov   [2];
  logic        irdy [2];
  opecode_e    oop  [2];
  logic [3:0]  oimm [2];
  logic [31:0] opc  [2];
  logic [1:0]  lvl2;
  logic [2:0]  lvl4;
`ifdef DECODE_QUEUE_TRAP_EN
  logic        otrap [2];
  logic [31:0] otpc  [2];
`endif

  ent_t        mq [2][$];
  bit          mtrap [2];
  logic [31:0] mtpc  [2];
  bit          acc   [2];
  int          dep   [2] = '{2, 4};
  opecode_e    ref_tbl [16];

  int n_cmp = 0;
  int n_err = 0;
  int n_inv = 0;
  int n_leg = 0;
  bit wrap_mode = 0;
  int wrap_next = 0;

  always #5 clk = ~clk;

  decode_queue #(.IMM_W(4), .PC_W(32), .DEPTH(2)) u_dq2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(irdy[0]),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_opecode_o(oop[0]), .out_imm_o(oimm[0]), .out_pc_o(opc[0]), .flush_i(flush),
`ifdef DECODE_QUEUE_TRAP_EN
    .trap_o(otrap[0]), .trap_clr_i(trap_clr), .trap_pc_o(otpc[0]),
`endif
    .level_o(lvl2)
  );

  decode_queue #(.IMM_W(4), .PC_W(32), .DEPTH(4)) u_dq4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(irdy[1]),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_opecode_o(oop[1]), .out_imm_o(oimm[1]), .out_pc_o(opc[1]), .flush_i(flush),
`ifdef DECODE_QUEUE_TRAP_EN
    .trap_o(otrap[1]), .trap_clr_i(trap_clr), .trap_pc_o(otpc[1]),
`endif
    .level_o(lvl4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mtrap[k] = 0;
      mtpc[k]  = '0;
      acc[k]   = 0;
    end
  endtask

  // Check the head against the model mid-cycle, then advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit mv;
      mv = mq[k].size() > 0;
      chk($sformatf("valid%0d", k), ov[k], mv);
      chk($sformatf("op%0d", k), oop[k], mv ? mq[k][0].op : INVALID);
      chk($sformatf("imm%0d", k), oimm[k], mv ? mq[k][0].imm : 4'h0);
      chk($sformatf("pc%0d", k), opc[k], mv ? mq[k][0].pc : 32'h0);
      chk($sformatf("level%0d", k), (k == 0) ? lvl2 : lvl4, mq[k].size());
      chk($sformatf("in_ready%0d", k), irdy[k], (mq[k].size() < dep[k]) && !mtrap[k]);
`ifdef DECODE_QUEUE_TRAP_EN
      chk($sformatf("trap%0d", k), otrap[k], mtrap[k]);
      chk($sformatf("trap_pc%0d", k), otpc[k], mtpc[k]);
`endif
    end
    if (ov[0] && out_ready) begin
      if (oop[0] == INVALID) n_inv++;
      else n_leg++;
    end
    if (wrap_mode && ov[1] && out_ready) begin
      chk("wrap_order", opc[1], wrap_next);
      wrap_next++;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit   rdy, do_pop, do_push;
      ent_t e;
      rdy = (mq[k].size() < dep[k]) && !mtrap[k];
      acc[k] = 0;
      e.op  = ref_tbl[in_instr[7:4]];
      e.imm = in_instr[3:0];
      e.pc  = in_pc;
      if (!rst_n) begin
        mq[k].delete();
        mtrap[k] = 0;
        mtpc[k]  = '0;
      end else if (flush) begin
        mq[k].delete();
        mtrap[k] = 0;
      end else begin
        do_pop  = (mq[k].size() > 0) && out_ready;
        do_push = in_valid && rdy;
        if (do_pop) mq[k].delete(0);
`ifdef DECODE_QUEUE_TRAP_EN
        if (mtrap[k] && trap_clr) mtrap[k] = 0;
        if (do_push && e.op == INVALID) begin
          mtrap[k] = 1;
          mtpc[k]  = in_pc;
          do_push  = 0;
        end
`endif
        if (do_push) begin
          mq[k].push_back(e);
          acc[k] = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_tbl[i] = INVALID;
    ref_tbl[4'b0001] = MOV_A_B;   ref_tbl[4'b0100] = MOV_B_A;
    ref_tbl[4'b0011] = MOV_A_IMM; ref_tbl[4'b0111] = MOV_B_IMM;
    ref_tbl[4'b0010] = IN_A;      ref_tbl[4'b0110] = IN_B;
    ref_tbl[4'b1001] = OUT_B;     ref_tbl[4'b1011] = OUT_IMM;
    ref_tbl[4'b0000] = ADD_A_IMM; ref_tbl[4'b0101] = ADD_B_IMM;
    ref_tbl[4'b1111] = JMP_IMM;   ref_tbl[4'b1110] = JNC_IMM;

    in_valid = 0; out_ready = 0; flush = 0; trap_clr = 0;
    in_instr = '0; in_pc = '0;
    model_clear();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Decode sweep: all 16 opcodes with imm A, streaming.
    in_valid = 1; out_ready = 1;
`ifdef DECODE_QUEUE_TRAP_EN
    trap_clr = 1;
`endif
    for (int op = 0; op < 16; op++) begin
      in_instr = {op[3:0], 4'hA};
      in_pc    = 32'(op);
      cycle();
    end
    in_valid = 0;
    repeat (3) cycle();
    trap_clr = 0;
`ifdef DECODE_QUEUE_TRAP_EN
    chk("sweep_invalid", n_inv, 0);
`else
    chk("sweep_invalid", n_inv, 4);
    chk("sweep_legal", n_leg, 12);
`endif

    // Fill: three offers into an idle DEPTH=2 queue.
    out_ready = 0; in_valid = 1; in_instr = 8'h35;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h100 + 32'(i);
      cycle();
    end
    chk("fill_level", lvl2, 2);
    chk("fill_in_ready", irdy[0], 0);
    chk("fill_head_pc", opc[0], 32'h100);

    // Flush with a word on offer: word dropped, queue empty next cycle.
    flush = 1; in_pc = 32'h200;
    cycle();
    flush = 0; in_valid = 0;
    chk("flush_level2", lvl2, 0);
    chk("flush_level4", lvl4, 0);
    chk("flush_valid", ov[0], 0);
    cycle();

    // Streaming: one entry per cycle, occupancy steady at 1.
    in_valid = 1; out_ready = 1; in_instr = 8'h17;
    for (int i = 0; i < 8; i++) begin
      in_pc = 32'h300 + 32'(i);
      cycle();
      chk("stream_level", lvl2, 1);
    end
    in_valid = 0;
    repeat (2) cycle();

    // Wrap: DEPTH=4 with random stalls, pcs 0..9 in order.
    wrap_mode = 1; wrap_next = 0; in_instr = 8'h7C;
    begin
      int pc_next = 0;
      int budget  = 300;
      while (wrap_next < 10 && budget > 0) begin
        in_valid  = (pc_next < 10) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        in_pc     = 32'(pc_next);
        cycle();
        if (acc[1]) pc_next++;
        budget--;
      end
      chk("wrap_done", wrap_next, 10);
    end
    wrap_mode = 0; in_valid = 0; out_ready = 1;
    repeat (5) cycle();

    // Illegal opcode 1000 at pc 0x40.
    out_ready = 0; in_valid = 1; in_instr = 8'h8A; in_pc = 32'h40;
    cycle();
    in_valid = 0;
`ifdef DECODE_QUEUE_TRAP_EN
    chk("trap_set", otrap[0], 1);
    chk("trap_pc", otpc[0], 32'h40);
    chk("trap_in_ready", irdy[0], 0);
    cycle();
    trap_clr = 1;
    cycle();
    trap_clr = 0;
    chk("trap_clr", otrap[0], 0);
    chk("trap_clr_in_ready", irdy[0], 1);
`else
    chk("invalid_fwd_op", oop[0], INVALID);
    chk("invalid_fwd_pc", opc[0], 32'h40);
`endif
    flush = 1;
    cycle();
    flush = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 15) == 0);
      trap_clr  = ($urandom_range(0, 7) == 0);
      in_instr  = 8'($urandom);
      in_pc     = $urandom;
      cycle();
    end

    // Asynchronous reset while occupied.
    flush = 0; trap_clr = 0; out_ready = 0; in_valid = 1; in_instr = 8'h29;
    repeat (3) cycle();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("areset_level4", lvl4, 0);
    chk("areset_valid", ov[1], 0);
    in_valid = 0;
    cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
